// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the RV32I ALU control path: ALUOp classes from the
// main decoder, the 4-bit ALU operation codes, and funct3 field values.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OPW = 4;

  // ALUOp classes produced by the main control decoder
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // ALU operation codes; 1010-1111 are never generated
  localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OPW-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OPW-1:0] ALU_SLL  = 4'b0010;
  localparam logic [OPW-1:0] ALU_SLT  = 4'b0011;
  localparam logic [OPW-1:0] ALU_SLTU = 4'b0100;
  localparam logic [OPW-1:0] ALU_XOR  = 4'b0101;
  localparam logic [OPW-1:0] ALU_SRL  = 4'b0110;
  localparam logic [OPW-1:0] ALU_SRA  = 4'b0111;
  localparam logic [OPW-1:0] ALU_OR   = 4'b1000;
  localparam logic [OPW-1:0] ALU_AND  = 4'b1001;

  // funct3 values for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_control_unit_if.sv
// ---------------------------------------------------------------------------
// alu_control_unit_if
// Bundles the decoder request (in_valid, ALUOp, funct3, funct7) and the
// registered response (ALUControl, out_valid, illegal).
//   master : drives the request, observes the response (main decoder / TB)
//   slave  : consumes the request, drives the response (alu_control_unit)
// ---------------------------------------------------------------------------
interface alu_control_unit_if
  import alu_pkg::*;
  ;
  logic           in_valid;
  logic [1:0]     ALUOp;
  logic [2:0]     funct3;
  logic           funct7;
  logic [OPW-1:0] ALUControl;
  logic           out_valid;
  logic           illegal;

  modport master (
    output in_valid, ALUOp, funct3, funct7,
    input  ALUControl, out_valid, illegal
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct7,
    output ALUControl, out_valid, illegal
  );
endinterface

// File: rtl/alu_control_decode.sv
// ---------------------------------------------------------------------------
// alu_control_decode
// Purely combinational map of (ALUOp, funct3, funct7[5]) onto an ALU op code.
// Undefined combinations yield ADD with o_illegal set.
// Ports:
//   i_aluop   [1:0]  class from main decoder
//   i_funct3  [2:0]  instruction bits [14:12]
//   i_funct7         instruction bit 30
//   o_op      [3:0]  ALU operation code
//   o_illegal        undefined encoding flag
// ---------------------------------------------------------------------------
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [1:0]     i_aluop,
  input  logic [2:0]     i_funct3,
  input  logic           i_funct7,
  output logic [OPW-1:0] o_op,
  output logic           o_illegal
);

  logic [OPW-1:0] w_base_op;

  // Operation selected by funct3 alone, shared by OP and OP-IMM
  always_comb begin
    w_base_op = ALU_ADD;
    case (i_funct3)
      F3_ADD:  w_base_op = ALU_ADD;
      F3_SLL:  w_base_op = ALU_SLL;
      F3_SLT:  w_base_op = ALU_SLT;
      F3_SLTU: w_base_op = ALU_SLTU;
      F3_XOR:  w_base_op = ALU_XOR;
      F3_SR:   w_base_op = ALU_SRL;
      F3_OR:   w_base_op = ALU_OR;
      F3_AND:  w_base_op = ALU_AND;
    endcase
  end

  always_comb begin
    o_op      = ALU_ADD;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_MEM: begin
        o_op = ALU_ADD;
      end

      ALUOP_BR: begin
        // funct3[2:1] selects the compare flavour; funct7 is not part of B-type
        case (i_funct3[2:1])
          2'b00: o_op = ALU_SUB;
          2'b10: o_op = ALU_SLT;
          2'b11: o_op = ALU_SLTU;
          2'b01: o_illegal = 1'b1;
        endcase
      end

      ALUOP_R: begin
        o_op = w_base_op;
        if (i_funct7) begin
          if (i_funct3 == F3_ADD) begin
            o_op = ALU_SUB;
          end else if (i_funct3 == F3_SR) begin
            o_op = ALU_SRA;
          end else begin
            o_op      = ALU_ADD;
            o_illegal = 1'b1;
          end
        end
      end

      ALUOP_I: begin
        // Bit 30 is immediate data except for the shift-immediate forms
        o_op = w_base_op;
        if (i_funct7) begin
          if (i_funct3 == F3_SR) begin
            o_op = ALU_SRA;
          end else if (i_funct3 == F3_SLL) begin
            o_op      = ALU_ADD;
            o_illegal = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
// Registered ALU-operation decoder between the main control decoder and the
// ALU. Accepted inputs (in_valid=1) are decoded and captured on the rising
// clock edge; ALUControl/illegal hold until the next accepted input while
// out_valid drops on idle cycles.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (outputs -> ADD, invalid, legal)
//   bus    alu_control_unit_if.slave (request in, registered response out)
// ---------------------------------------------------------------------------
module alu_control_unit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_control_unit_if.slave  bus
);

  logic [OPW-1:0] w_op;
  logic           w_illegal;

  logic [OPW-1:0] r_alu_control;
  logic           r_out_valid;
  logic           r_illegal;

  alu_control_decode u_decode (
    .i_aluop   (bus.ALUOp),
    .i_funct3  (bus.funct3),
    .i_funct7  (bus.funct7),
    .o_op      (w_op),
    .o_illegal (w_illegal)
  );

  // Decode results only load when in_valid is high, so garbage on the
  // request fields during idle cycles never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_control <= ALU_ADD;
      r_out_valid   <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_alu_control <= w_op;
        r_illegal     <= w_illegal;
      end
    end
  end

  assign bus.ALUControl = r_alu_control;
  assign bus.out_valid  = r_out_valid;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  logic clk;
  logic rst_n;

  alu_control_unit_if bus ();

  alu_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output state, tracked by the reference model
  logic [3:0] exp_ctrl;
  logic       exp_valid;
  logic       exp_ill;

  // Op code chosen by funct3 for OP/OP-IMM when bit 30 plays no role
  logic [3:0] f3_tab [8];

  // Reference decode, written straight from the opcode tables
  function automatic void ref_dec(input logic [1:0] aop, input logic [2:0] f3,
                                  input logic f7, output logic [3:0] op,
                                  output logic ill);
    op  = 4'd0;
    ill = 1'b0;
    if (aop == 2'd1) begin
      if (f3 == 3'd0 || f3 == 3'd1)      op = 4'd1;
      else if (f3 == 3'd4 || f3 == 3'd5) op = 4'd3;
      else if (f3 == 3'd6 || f3 == 3'd7) op = 4'd4;
      else                               ill = 1'b1;
    end else if (aop == 2'd2) begin
      op = f3_tab[f3];
      if (f7) begin
        if (f3 == 3'd0)      op = 4'd1;
        else if (f3 == 3'd5) op = 4'd7;
        else begin op = 4'd0; ill = 1'b1; end
      end
    end else if (aop == 2'd3) begin
      op = f3_tab[f3];
      if (f7 && f3 == 3'd5) op = 4'd7;
      if (f7 && f3 == 3'd1) begin op = 4'd0; ill = 1'b1; end
    end
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ctrl"},  bus.ALUControl,      exp_ctrl);
    check({tag, ".valid"}, {3'b0, bus.out_valid}, {3'b0, exp_valid});
    check({tag, ".ill"},   {3'b0, bus.illegal},   {3'b0, exp_ill});
  endtask

  // Drive one cycle's request, let the edge happen, update model, check.
  task automatic step(input string tag, input logic v, input logic [1:0] aop,
                      input logic [2:0] f3, input logic f7);
    logic [3:0] op;
    logic       ill;
    @(negedge clk);
    bus.in_valid = v;
    bus.ALUOp    = aop;
    bus.funct3   = f3;
    bus.funct7   = f7;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      ref_dec(aop, f3, f7, op, ill);
      exp_ctrl = op;
      exp_ill  = ill;
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_ctrl  = 4'd0;
    exp_valid = 1'b0;
    exp_ill   = 1'b0;
  endtask

  initial begin
    f3_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    // Reset with no clock edge
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.ALUOp    = 2'b00;
    bus.funct3   = 3'b000;
    bus.funct7   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");

    @(negedge clk);
    rst_n = 1'b1;
    step("first_add", 1'b1, 2'b00, 3'b000, 1'b0);
    check("first_add.abs", bus.ALUControl, 4'b0000);

    // R-type sweep
    for (int i = 0; i < 8; i++) step($sformatf("r_f3_%0d", i), 1'b1, 2'b10, 3'(i), 1'b0);
    step("r_sub", 1'b1, 2'b10, 3'b000, 1'b1);
    check("r_sub.abs", bus.ALUControl, 4'b0001);
    step("r_sra", 1'b1, 2'b10, 3'b101, 1'b1);
    check("r_sra.abs", bus.ALUControl, 4'b0111);
    step("r_and_f7", 1'b1, 2'b10, 3'b111, 1'b1);
    check("r_and_f7.ill", {3'b0, bus.illegal}, 4'd1);

    // I-type
    step("i_addi_f7", 1'b1, 2'b11, 3'b000, 1'b1);
    check("i_addi_f7.abs", bus.ALUControl, 4'b0000);
    step("i_srai", 1'b1, 2'b11, 3'b101, 1'b1);
    check("i_srai.abs", bus.ALUControl, 4'b0111);
    step("i_slli_f7", 1'b1, 2'b11, 3'b001, 1'b1);
    step("i_xori_f7", 1'b1, 2'b11, 3'b100, 1'b1);

    // Branch
    step("br_bne",  1'b1, 2'b01, 3'b001, 1'b0);
    check("br_bne.abs", bus.ALUControl, 4'b0001);
    step("br_bge",  1'b1, 2'b01, 3'b101, 1'b1);
    check("br_bge.abs", bus.ALUControl, 4'b0011);
    step("br_bgeu", 1'b1, 2'b01, 3'b111, 1'b0);
    check("br_bgeu.abs", bus.ALUControl, 4'b0100);
    step("br_010",  1'b1, 2'b01, 3'b010, 1'b0);
    check("br_010.ill", {3'b0, bus.illegal}, 4'd1);

    // Hold: accept AND, then idle cycles with random inputs
    step("hold_and", 1'b1, 2'b10, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold_%0d", i), 1'b0, 2'($urandom), 3'($urandom), 1'($urandom));
      check($sformatf("hold_%0d.abs", i), bus.ALUControl, 4'b1001);
    end

    // Async reset between edges while out_valid=1
    step("pre_rst", 1'b1, 2'b10, 3'b101, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUOp    = 2'b10;
    bus.funct3   = 3'b010;
    bus.funct7   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 2'b11, 3'b110, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rand_%0d", i), 1'($urandom_range(0, 3) != 0),
           2'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
